// File: rtl/dma_bus_arbiter.sv
// DMA bus arbiter: IDLE/GRANT/RELEASE burst FSM with fixed-priority arbitration.
// Define DMA_ARB_RR_EN to switch to round-robin arbitration.
module dma_bus_arbiter #(
  parameter int NUM_CH    = 2,
  parameter int BURST_LEN = 12,
  parameter int CNT_W     = 8,
  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [NUM_CH-1:0] BR,
  input  logic              cpu_mem_busy,
  output logic [NUM_CH-1:0] BG,
  output logic              bus_busy,
  output logic [IW-1:0]     grant_id,
  output logic [CNT_W-1:0]  burst_cnt,
  output logic              burst_done,
  output logic              burst_abort
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    RELEASE
  } state_t;

  state_t            state;
  logic [IW-1:0]     win;
  logic [NUM_CH-1:0] win_oh;
  logic              found;
  logic              own_req;
  logic              last;
  logic              leave;

  // BG is one-hot on the owner during GRANT, so this is BR[owner]
  assign own_req  = |(BR & BG);
  assign last     = (burst_cnt == CNT_W'(BURST_LEN - 1));
  assign leave    = (state == GRANT) && (last || !own_req);
  assign bus_busy = |BG;

`ifdef DMA_ARB_RR_EN
  logic [IW-1:0] rr_ptr;

  // Two passes: channels at/above the pointer first, then wrap to the bottom
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int j = 0; j < NUM_CH; j++) begin
      if (!found && BR[j] && (IW'(j) >= rr_ptr)) begin
        found = 1'b1;
        win   = IW'(j);
      end
    end
    for (int j = 0; j < NUM_CH; j++) begin
      if (!found && BR[j]) begin
        found = 1'b1;
        win   = IW'(j);
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rr_ptr <= '0;
    end else if (leave) begin
      if (grant_id == IW'(NUM_CH - 1))
        rr_ptr <= '0;
      else
        rr_ptr <= grant_id + 1'b1;
    end
  end
`else
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int j = 0; j < NUM_CH; j++) begin
      if (!found && BR[j]) begin
        found = 1'b1;
        win   = IW'(j);
      end
    end
  end
`endif

  always_comb begin
    win_oh = '0;
    for (int j = 0; j < NUM_CH; j++)
      win_oh[j] = found && (win == IW'(j));
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      BG          <= '0;
      grant_id    <= '0;
      burst_cnt   <= '0;
      burst_done  <= 1'b0;
      burst_abort <= 1'b0;
    end else begin
      burst_done  <= 1'b0;
      burst_abort <= 1'b0;
      unique case (state)
        IDLE: begin
          if ((|BR) && !cpu_mem_busy) begin
            state     <= GRANT;
            BG        <= win_oh;
            grant_id  <= win;
            burst_cnt <= '0;
          end
        end
        GRANT: begin
          if (leave) begin
            state       <= RELEASE;
            BG          <= '0;
            burst_cnt   <= '0;
            burst_done  <= last;
            burst_abort <= !last;
          end else begin
            burst_cnt <= burst_cnt + 1'b1;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Directed testbench for dma_bus_arbiter (NUM_CH=3, BURST_LEN=12).
// Vector table for short multi-channel cases, hand sequences for long bursts.
module tb_dma_bus_arbiter;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [2:0] BR;
  logic       cpu_mem_busy;
  logic [2:0] BG;
  logic       bus_busy;
  logic [1:0] grant_id;
  logic [7:0] burst_cnt;
  logic       burst_done;
  logic       burst_abort;

  int checks = 0;
  int errors = 0;

  dma_bus_arbiter #(
    .NUM_CH   (3),
    .BURST_LEN(12),
    .CNT_W    (8)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .BR          (BR),
    .cpu_mem_busy(cpu_mem_busy),
    .BG          (BG),
    .bus_busy    (bus_busy),
    .grant_id    (grant_id),
    .burst_cnt   (burst_cnt),
    .burst_done  (burst_done),
    .burst_abort (burst_abort)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [2:0] br;
    logic       busy;
    logic [2:0] bg;
    logic [1:0] gid;
    logic [7:0] cnt;
    logic       done;
    logic       abort;
  } vec_t;

  vec_t vt[10];
  int   exp_seq[4];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_all(input string name, input logic [2:0] bg,
                         input logic [1:0] gid, input logic [7:0] cnt,
                         input logic done, input logic abort);
    chk({name, ".BG"}, int'(BG), int'(bg));
    chk({name, ".bus_busy"}, int'(bus_busy), int'(|bg));
    chk({name, ".grant_id"}, int'(grant_id), int'(gid));
    chk({name, ".burst_cnt"}, int'(burst_cnt), int'(cnt));
    chk({name, ".done"}, int'(burst_done), int'(done));
    chk({name, ".abort"}, int'(burst_abort), int'(abort));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{3'b010, 1'b0, 3'b010, 2'd1, 8'd0, 1'b0, 1'b0};
    vt[1] = '{3'b011, 1'b0, 3'b010, 2'd1, 8'd1, 1'b0, 1'b0};
    vt[2] = '{3'b001, 1'b0, 3'b000, 2'd1, 8'd0, 1'b0, 1'b1};
    vt[3] = '{3'b001, 1'b0, 3'b000, 2'd1, 8'd0, 1'b0, 1'b0};
    vt[4] = '{3'b001, 1'b1, 3'b000, 2'd1, 8'd0, 1'b0, 1'b0};
    vt[5] = '{3'b100, 1'b0, 3'b100, 2'd2, 8'd0, 1'b0, 1'b0};
    vt[6] = '{3'b110, 1'b1, 3'b100, 2'd2, 8'd1, 1'b0, 1'b0};
    vt[7] = '{3'b000, 1'b0, 3'b000, 2'd2, 8'd0, 1'b0, 1'b1};
    vt[8] = '{3'b000, 1'b0, 3'b000, 2'd2, 8'd0, 1'b0, 1'b0};
    vt[9] = '{3'b000, 1'b0, 3'b000, 2'd2, 8'd0, 1'b0, 1'b0};
`ifdef DMA_ARB_RR_EN
    exp_seq = '{0, 1, 2, 0};
`else
    exp_seq = '{0, 0, 0, 0};
`endif

    Reset = 1'b1;
    BR = '0;
    cpu_mem_busy = 1'b0;
    step();
    step();
    chk_all("reset", 3'b000, 2'd0, 8'd0, 1'b0, 1'b0);

    // Full-length burst on channel 0, then the 2-cycle gap and re-grant
    Reset = 1'b0;
    BR = 3'b001;
    step();
    chk_all("first_grant", 3'b001, 2'd0, 8'd0, 1'b0, 1'b0);
    for (int i = 1; i < 12; i++) begin
      step();
      chk("full.cnt", int'(burst_cnt), i);
      chk("full.BG", int'(BG), 1);
    end
    step();
    chk_all("full.release", 3'b000, 2'd0, 8'd0, 1'b1, 1'b0);
    step();
    chk_all("full.idle", 3'b000, 2'd0, 8'd0, 1'b0, 1'b0);
    step();
    chk_all("full.regrant", 3'b001, 2'd0, 8'd0, 1'b0, 1'b0);

    // Owner drops request at burst_cnt=5
    for (int i = 0; i < 5; i++) step();
    chk("abort.cnt5", int'(burst_cnt), 5);
    BR = 3'b000;
    step();
    chk_all("abort.release", 3'b000, 2'd0, 8'd0, 1'b0, 1'b1);
    step();
    chk_all("abort.idle", 3'b000, 2'd0, 8'd0, 1'b0, 1'b0);

    // CPU busy blocks the grant for 7 cycles
    BR = 3'b001;
    cpu_mem_busy = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      chk("busy.BG", int'(BG), 0);
    end
    cpu_mem_busy = 1'b0;
    step();
    chk_all("busy.grant", 3'b001, 2'd0, 8'd0, 1'b0, 1'b0);
    BR = 3'b000;
    step();
    step();

    // Full length and request drop on the same cycle
    BR = 3'b001;
    step();
    chk("coin.grant", int'(BG), 1);
    for (int i = 0; i < 11; i++) step();
    chk("coin.cnt11", int'(burst_cnt), 11);
    BR = 3'b000;
    step();
    chk_all("coin.release", 3'b000, 2'd0, 8'd0, 1'b1, 1'b0);
    step();

    for (int i = 0; i < 10; i++) begin
      BR = vt[i].br;
      cpu_mem_busy = vt[i].busy;
      step();
      chk_all($sformatf("vec%0d", i), vt[i].bg, vt[i].gid, vt[i].cnt,
              vt[i].done, vt[i].abort);
    end

    // All channels requesting: grant order and per-burst length
    BR = 3'b111;
    cpu_mem_busy = 1'b0;
    for (int b = 0; b < 4; b++) begin
      int n;
      int hi;
      n = 0;
      while (BG == 3'b000 && n < 20) begin
        step();
        n++;
      end
      chk($sformatf("arb%0d.seen", b), int'(BG != 3'b000), 1);
      if (b > 0) chk($sformatf("arb%0d.gap", b), n, 2);
      chk($sformatf("arb%0d.gid", b), int'(grant_id), exp_seq[b]);
      hi = 0;
      while (BG != 3'b000 && hi < 20) begin
        hi++;
        step();
      end
      chk($sformatf("arb%0d.len", b), hi, 12);
      chk($sformatf("arb%0d.done", b), int'(burst_done), 1);
    end

    // Reset mid-burst on channel 1 at burst_cnt=4
    BR = 3'b010;
    step();
    step();
    chk_all("rst.grant", 3'b010, 2'd1, 8'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step();
    chk("rst.cnt4", int'(burst_cnt), 4);
    #1 Reset = 1'b1;
    #1;
    chk_all("rst.async", 3'b000, 2'd0, 8'd0, 1'b0, 1'b0);
    step();
    chk_all("rst.hold", 3'b000, 2'd0, 8'd0, 1'b0, 1'b0);
    Reset = 1'b0;
    BR = 3'b011;
    step();
    chk_all("rst.regrant", 3'b001, 2'd0, 8'd0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
